regfile_scoreboard: RTL and testbench

//  Parametrised successor of the core's 32x32 register file. Holds NREGS x XLEN

---
 rtl/regfile_scoreboard.sv | 90 +++++++++
 tb/tb_regfile_scoreboard.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// NREGS x XLEN register file: two combinational read ports, one write-back port, optional write-to-read bypass.
// A per-register pending scoreboard (set at issue, cleared at write-back) drives the RAW/WAW busy flags and a registered pend_cnt.
module regfile_scoreboard #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter bit BYPASS = 1'b1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            rd_busy,
   input  logic            flush,
   output logic [AW:0]     pend_cnt
);

   localparam logic [AW:0] CNT_ONE = 1;

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pend_nxt;
   logic [AW:0]      cnt_nxt;
   logic             wr_en;
   logic             set_en;
   logic             set_new;
   logic             clr_eff;

   assign wr_en  = we && (wa != '0);
   assign set_en = iss_valid && (iss_rd != '0);

   // Only transitions that actually flip a pending bit move the counter; set wins over a same-register clear.
   assign set_new = set_en && !pending[iss_rd];
   assign clr_eff = wr_en && pending[wa] && !(set_en && (iss_rd == wa));

   always_comb begin
      pend_nxt = pending;
      cnt_nxt  = pend_cnt;
      if (wr_en)
         pend_nxt[wa] = 1'b0;
      if (set_en)
         pend_nxt[iss_rd] = 1'b1;
      if (set_new && !clr_eff)
         cnt_nxt = pend_cnt + CNT_ONE;
      else if (clr_eff && !set_new)
         cnt_nxt = pend_cnt - CNT_ONE;
      if (flush) begin
         pend_nxt = '0;
         cnt_nxt  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
         pending  <= '0;
         pend_cnt <= '0;
      end else begin
         if (wr_en)
            regs[wa] <= wd;
         pending  <= pend_nxt;
         pend_cnt <= cnt_nxt;
      end
   end

   // Outputs are forced quiet while reset is held, even if a bypassed write is presented.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rst && (rs1_addr != '0))
         rs1_data = (BYPASS && wr_en && (wa == rs1_addr)) ? wd : regs[rs1_addr];
      if (rst && (rs2_addr != '0))
         rs2_data = (BYPASS && wr_en && (wa == rs2_addr)) ? wd : regs[rs2_addr];
   end

   assign rs1_busy = rst && pending[rs1_addr] && !(BYPASS && wr_en && (wa == rs1_addr));
   assign rs2_busy = rst && pending[rs2_addr] && !(BYPASS && wr_en && (wa == rs2_addr));
   assign rd_busy  = rst && pending[iss_rd];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench driving a bypassing and a non-bypassing register file from the same stimulus.
module tb_regfile_scoreboard;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1_addr, rs2_addr, wa, iss_rd;
   logic [31:0] wd;
   logic        we, iss_valid, flush;

   logic [31:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
   logic        b_rs1_busy, b_rs2_busy, b_rd_busy;
   logic        n_rs1_busy, n_rs2_busy, n_rd_busy;
   logic [5:0]  b_pend_cnt, n_pend_cnt;

   int total = 0;
   int bad   = 0;

   regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) u_byp (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
      .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
      .we(we), .wa(wa), .wd(wd),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .rd_busy(b_rd_busy),
      .flush(flush), .pend_cnt(b_pend_cnt)
   );

   regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) u_nob (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
      .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
      .we(we), .wa(wa), .wd(wd),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .rd_busy(n_rd_busy),
      .flush(flush), .pend_cnt(n_pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      we = 1'b0; iss_valid = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst = 1'b0; idle();
      rs1_addr = '0; rs2_addr = '0; wa = '0; iss_rd = '0; wd = '0;

      // Reset held with a live write/issue to reg 5
      we = 1'b1; wa = 5'd5; wd = 32'hDEAD; rs1_addr = 5'd5; rs2_addr = 5'd5;
      iss_valid = 1'b1; iss_rd = 5'd5;
      tick(); tick();
      chk("rst_rs1_data_byp", b_rs1_data, 32'h0);
      chk("rst_rs1_data_nob", n_rs1_data, 32'h0);
      chk("rst_rs1_busy", b_rs1_busy, 1'b0);
      chk("rst_rd_busy", b_rd_busy, 1'b0);
      chk("rst_pend_cnt", b_pend_cnt, 6'd0);
      idle();
      #1 rst = 1'b1;
      tick();
      chk("post_rst_reg5", b_rs1_data, 32'h0);
      chk("post_rst_cnt", n_pend_cnt, 6'd0);

      // Write then read; write to reg 0 ignored
      we = 1'b1; wa = 5'd3; wd = 32'h12345678;
      tick();
      idle(); rs1_addr = 5'd3;
      #1;
      chk("wr_rd3_byp", b_rs1_data, 32'h12345678);
      chk("wr_rd3_nob", n_rs1_data, 32'h12345678);
      we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; rs2_addr = 5'd0;
      #1;
      chk("wr0_same_cycle", b_rs2_data, 32'h0);
      tick();
      idle();
      #1;
      chk("wr0_after_edge", b_rs2_data, 32'h0);
      chk("wr0_cnt", b_pend_cnt, 6'd0);

      // Bypass versus no bypass
      we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; rs2_addr = 5'd7;
      #1;
      chk("byp_rs2_data", b_rs2_data, 32'hA5A5A5A5);
      chk("byp_rs2_busy", b_rs2_busy, 1'b0);
      chk("nob_rs2_old", n_rs2_data, 32'h0);
      tick();
      idle();
      #1;
      chk("nob_rs2_new", n_rs2_data, 32'hA5A5A5A5);

      // Scoreboard set/clear
      iss_valid = 1'b1; iss_rd = 5'd4;
      #1;
      chk("iss4_rd_busy_pre", b_rd_busy, 1'b0);
      tick();
      idle(); rs1_addr = 5'd4;
      #1;
      chk("iss4_rs1_busy_byp", b_rs1_busy, 1'b1);
      chk("iss4_rs1_busy_nob", n_rs1_busy, 1'b1);
      chk("iss4_cnt", b_pend_cnt, 6'd1);
      chk("iss4_rd_busy", n_rd_busy, 1'b1);
      we = 1'b1; wa = 5'd4; wd = 32'h44;
      #1;
      chk("wb4_busy_byp", b_rs1_busy, 1'b0);
      chk("wb4_busy_nob", n_rs1_busy, 1'b1);
      chk("wb4_data_byp", b_rs1_data, 32'h44);
      tick();
      idle();
      #1;
      chk("wb4_busy_after", n_rs1_busy, 1'b0);
      chk("wb4_cnt_after", b_pend_cnt, 6'd0);
      chk("wb4_data_after", n_rs1_data, 32'h44);

      // Simultaneous set/clear
      iss_valid = 1'b1; iss_rd = 5'd9;
      tick();
      iss_valid = 1'b1; iss_rd = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h99;
      tick();
      idle(); rs1_addr = 5'd9;
      #1;
      chk("sim9_busy", n_rs1_busy, 1'b1);
      chk("sim9_cnt", b_pend_cnt, 6'd1);
      iss_valid = 1'b1; iss_rd = 5'd10; we = 1'b1; wa = 5'd9; wd = 32'h999;
      tick();
      idle(); rs1_addr = 5'd10; rs2_addr = 5'd9;
      #1;
      chk("sim10_cnt", n_pend_cnt, 6'd1);
      chk("sim10_busy10", b_rs1_busy, 1'b1);
      chk("sim10_busy9", n_rs2_busy, 1'b0);
      chk("sim10_data9", n_rs2_data, 32'h999);

      // Flush
      we = 1'b1; wa = 5'd10; wd = 32'h10;
      tick();
      idle();
      for (int r = 1; r <= 3; r++) begin
         iss_valid = 1'b1; iss_rd = r[4:0];
         tick();
      end
      idle();
      #1;
      chk("fl_cnt3", b_pend_cnt, 6'd3);
      flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4; we = 1'b1; wa = 5'd5; wd = 32'h7;
      tick();
      idle(); rs1_addr = 5'd1; rs2_addr = 5'd4; iss_rd = 5'd3;
      #1;
      chk("fl_cnt0", b_pend_cnt, 6'd0);
      chk("fl_busy1", n_rs1_busy, 1'b0);
      chk("fl_busy4", b_rs2_busy, 1'b0);
      chk("fl_rd_busy3", b_rd_busy, 1'b0);
      rs1_addr = 5'd5;
      #1;
      chk("fl_reg5", n_rs1_data, 32'h7);

      // Issue to reg 0 is ignored
      iss_valid = 1'b1; iss_rd = 5'd0;
      tick();
      idle();
      #1;
      chk("iss0_cnt", b_pend_cnt, 6'd0);
      chk("iss0_rd_busy", b_rd_busy, 1'b0);

      // Mid-operation reset
      iss_valid = 1'b1; iss_rd = 5'd6;
      tick();
      idle(); rs2_addr = 5'd6;
      #1;
      chk("mid_cnt_pre", n_pend_cnt, 6'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_cnt", n_pend_cnt, 6'd0);
      chk("mid_rst_data5", b_rs1_data, 32'h0);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy6", n_rs2_busy, 1'b0);
      chk("mid_rst_reg5", n_rs1_data, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
